// File: rtl/scr1_vec_pkg.sv
// Shared vector-unit types: lane/register geometry, VRF element type,
// write-beat record and the write-port arbiter state encoding.
package scr1_vec_pkg;

    localparam int unsigned SCR1_VEC_LANE = 8;
    localparam int unsigned SCR1_VREG_NUM = 32;
    localparam int unsigned SCR1_VREG_AW  = 5;
    localparam int unsigned SCR1_VRF_EW   = 32;

    typedef logic [SCR1_VRF_EW-1:0] type_scr1_vrf_e_v;

    typedef struct packed {
        logic [SCR1_VREG_AW-1:0]                addr;
        logic [SCR1_VEC_LANE-1:0]               lane_en;
        type_scr1_vrf_e_v [SCR1_VEC_LANE-1:0]   data;
        logic                                   last;
    } type_vrf_wr_beat_s;

    typedef enum logic [1:0] {
        VRF_WR_IDLE     = 2'd0,
        VRF_WR_LOCK_EXU = 2'd1,
        VRF_WR_LOCK_LSU = 2'd2
    } type_vrf_wr_sched_fsm_e;

endpackage

// File: rtl/vrf_wr_sched_if.sv
// Bundle of issue, EXU/LSU writeback, VRF write and scoreboard signals
// around the VRF write-port scheduler.
interface vrf_wr_sched_if
    import scr1_vec_pkg::*;
#(
    parameter int unsigned LANE     = SCR1_VEC_LANE,
    parameter int unsigned VREG_NUM = SCR1_VREG_NUM
);

    logic                            issue_vld;
    logic [SCR1_VREG_AW-1:0]         issue_rs1_addr;
    logic [SCR1_VREG_AW-1:0]         issue_rs2_addr;
    logic [SCR1_VREG_AW-1:0]         issue_rd_addr;
    logic                            issue_rs1_used;
    logic                            issue_rs2_used;
    logic                            issue_rd_used;
    logic                            issue_masked;
    logic                            issue_rdy;

    logic                            exu_wr_vld;
    logic                            exu_wr_rdy;
    logic [SCR1_VREG_AW-1:0]         exu_wr_addr;
    logic [LANE-1:0]                 exu_wr_lane_en;
    type_scr1_vrf_e_v [LANE-1:0]     exu_wr_data;
    logic                            exu_wr_last;

    logic                            lsu_wr_vld;
    logic                            lsu_wr_rdy;
    logic [SCR1_VREG_AW-1:0]         lsu_wr_addr;
    logic [LANE-1:0]                 lsu_wr_lane_en;
    type_scr1_vrf_e_v [LANE-1:0]     lsu_wr_data;
    logic                            lsu_wr_last;

    logic [SCR1_VREG_AW-1:0]         vrf_wr_addr;
    logic [LANE-1:0]                 vrf_wr_wreq;
    type_scr1_vrf_e_v [LANE-1:0]     vrf_wr_wdata;
    logic [VREG_NUM-1:0]             sb_busy;

    modport slave (
        input  issue_vld, issue_rs1_addr, issue_rs2_addr, issue_rd_addr,
        input  issue_rs1_used, issue_rs2_used, issue_rd_used, issue_masked,
        output issue_rdy,
        input  exu_wr_vld, exu_wr_addr, exu_wr_lane_en, exu_wr_data, exu_wr_last,
        output exu_wr_rdy,
        input  lsu_wr_vld, lsu_wr_addr, lsu_wr_lane_en, lsu_wr_data, lsu_wr_last,
        output lsu_wr_rdy,
        output vrf_wr_addr, vrf_wr_wreq, vrf_wr_wdata, sb_busy
    );

    modport master (
        output issue_vld, issue_rs1_addr, issue_rs2_addr, issue_rd_addr,
        output issue_rs1_used, issue_rs2_used, issue_rd_used, issue_masked,
        input  issue_rdy,
        output exu_wr_vld, exu_wr_addr, exu_wr_lane_en, exu_wr_data, exu_wr_last,
        input  exu_wr_rdy,
        output lsu_wr_vld, lsu_wr_addr, lsu_wr_lane_en, lsu_wr_data, lsu_wr_last,
        input  lsu_wr_rdy,
        input  vrf_wr_addr, vrf_wr_wreq, vrf_wr_wdata, sb_busy
    );

endinterface

// File: rtl/vrf_scoreboard.sv
// Per-register busy bits for pending vector writes and the RAW/WAW/mask
// hazard check that gates the issue stage.
module vrf_scoreboard
    import scr1_vec_pkg::*;
#(
    parameter int unsigned VREG_NUM = SCR1_VREG_NUM
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_vld_i,
    input  logic [SCR1_VREG_AW-1:0] rs1_addr_i,
    input  logic [SCR1_VREG_AW-1:0] rs2_addr_i,
    input  logic [SCR1_VREG_AW-1:0] rd_addr_i,
    input  logic                    rs1_used_i,
    input  logic                    rs2_used_i,
    input  logic                    rd_used_i,
    input  logic                    masked_i,
    input  logic                    clr_vld_i,
    input  logic [SCR1_VREG_AW-1:0] clr_addr_i,
    output logic                    issue_rdy_o,
    output logic [VREG_NUM-1:0]     busy_o
);

    logic [VREG_NUM-1:0] busy_q;
    logic [VREG_NUM-1:0] busy_d;
    logic                set_vld;

    // Mask operand always lives in v1.
    assign issue_rdy_o = ~(rs1_used_i & busy_q[rs1_addr_i])
                       & ~(rs2_used_i & busy_q[rs2_addr_i])
                       & ~(rd_used_i  & busy_q[rd_addr_i])
                       & ~(masked_i   & busy_q[1]);

    assign set_vld = issue_vld_i & issue_rdy_o & rd_used_i;

    // Set applied after clear: a new writer claiming a register whose stale
    // (non-tracked) write completes this edge must stay busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_vld_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_vld) begin
            busy_d[rd_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/vrf_wr_sched.sv
// VRF write-port scheduler: burst-locking round-robin arbiter between EXU
// and LSU writeback, one-stage registered write port, hazard scoreboard.
module vrf_wr_sched
    import scr1_vec_pkg::*;
#(
    parameter int unsigned LANE     = SCR1_VEC_LANE,
    parameter int unsigned VREG_NUM = SCR1_VREG_NUM
) (
    input  logic          clk,
    input  logic          rst_n,
    vrf_wr_sched_if.slave bus
);

    type_vrf_wr_sched_fsm_e state_q, state_d;
    logic                   rr_lsu_q, rr_lsu_d;
    logic                   gnt_exu, gnt_lsu, gnt_any, gnt_last;
    type_vrf_wr_beat_s      sel_beat;
    type_vrf_wr_beat_s      beat_q;
    logic                   out_vld_q;
    logic [LANE-1:0]        wreq_mask;

    always_comb begin
        state_d  = state_q;
        rr_lsu_d = rr_lsu_q;
        gnt_exu  = 1'b0;
        gnt_lsu  = 1'b0;
        case (state_q)
            VRF_WR_IDLE: begin
                if (bus.exu_wr_vld && (!bus.lsu_wr_vld || !rr_lsu_q)) begin
                    gnt_exu = 1'b1;
                end else if (bus.lsu_wr_vld) begin
                    gnt_lsu = 1'b1;
                end
            end
            VRF_WR_LOCK_EXU: gnt_exu = bus.exu_wr_vld;
            VRF_WR_LOCK_LSU: gnt_lsu = bus.lsu_wr_vld;
            default:         state_d = VRF_WR_IDLE;
        endcase
        if (gnt_exu) begin
            state_d = bus.exu_wr_last ? VRF_WR_IDLE : VRF_WR_LOCK_EXU;
            if (bus.exu_wr_last) begin
                rr_lsu_d = 1'b1;
            end
        end else if (gnt_lsu) begin
            state_d = bus.lsu_wr_last ? VRF_WR_IDLE : VRF_WR_LOCK_LSU;
            if (bus.lsu_wr_last) begin
                rr_lsu_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= VRF_WR_IDLE;
            rr_lsu_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_lsu_q <= rr_lsu_d;
        end
    end

    assign bus.exu_wr_rdy = gnt_exu;
    assign bus.lsu_wr_rdy = gnt_lsu;
    assign gnt_any        = gnt_exu | gnt_lsu;
    assign gnt_last       = gnt_lsu ? bus.lsu_wr_last : bus.exu_wr_last;

    always_comb begin
        sel_beat         = '0;
        sel_beat.addr    = gnt_lsu ? bus.lsu_wr_addr    : bus.exu_wr_addr;
        sel_beat.lane_en = gnt_lsu ? bus.lsu_wr_lane_en : bus.exu_wr_lane_en;
        sel_beat.data    = gnt_lsu ? bus.lsu_wr_data    : bus.exu_wr_data;
        sel_beat.last    = gnt_last;
    end

    // Address/data hold their last value when idle; only wreq is qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= gnt_any;
            if (gnt_any) begin
                beat_q <= sel_beat;
            end
        end
    end

    assign wreq_mask        = {LANE{out_vld_q}};
    assign bus.vrf_wr_addr  = beat_q.addr;
    assign bus.vrf_wr_wreq  = beat_q.lane_en & wreq_mask;
    assign bus.vrf_wr_wdata = beat_q.data;

    vrf_scoreboard #(
        .VREG_NUM (VREG_NUM)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_vld_i (bus.issue_vld),
        .rs1_addr_i  (bus.issue_rs1_addr),
        .rs2_addr_i  (bus.issue_rs2_addr),
        .rd_addr_i   (bus.issue_rd_addr),
        .rs1_used_i  (bus.issue_rs1_used),
        .rs2_used_i  (bus.issue_rs2_used),
        .rd_used_i   (bus.issue_rd_used),
        .masked_i    (bus.issue_masked),
        .clr_vld_i   (out_vld_q & beat_q.last),
        .clr_addr_i  (beat_q.addr),
        .issue_rdy_o (bus.issue_rdy),
        .busy_o      (bus.sb_busy)
    );

endmodule

// File: tb/tb_vrf_wr_sched.sv
// Directed bench for vrf_wr_sched: arbitration, output latency, scoreboard
// hazards, partial lanes and asynchronous reset mid-burst.
module tb_vrf_wr_sched;
    import scr1_vec_pkg::*;

    localparam logic [255:0] DAT_A1 = {8{32'hA1A1_0001}};
    localparam logic [255:0] DAT_A2 = {8{32'hA2A2_0002}};
    localparam logic [255:0] DAT_A3 = {8{32'hA3A3_0003}};
    localparam logic [255:0] DAT_B1 = {8{32'hB1B1_0001}};
    localparam logic [255:0] DAT_C1 = {8{32'hC1C1_0001}};
    localparam logic [255:0] DAT_C2 = {8{32'hC2C2_0002}};
    localparam logic [255:0] DAT_D1 = {8{32'hD1D1_0001}};
    localparam logic [255:0] DAT_E1 = {8{32'hE1E1_0001}};
    localparam logic [255:0] DAT_F1 = {8{32'hF1F1_0001}};

    logic clk = 1'b0;
    logic rst_n;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    vrf_wr_sched_if #(.LANE(8), .VREG_NUM(32)) vif ();

    vrf_wr_sched #(.LANE(8), .VREG_NUM(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exu_beat(input logic [4:0] a, input logic [7:0] le, input logic [255:0] d, input logic l);
        vif.exu_wr_vld = 1'b1; vif.exu_wr_addr = a; vif.exu_wr_lane_en = le;
        vif.exu_wr_data = d; vif.exu_wr_last = l;
    endtask

    task automatic lsu_beat(input logic [4:0] a, input logic [7:0] le, input logic [255:0] d, input logic l);
        vif.lsu_wr_vld = 1'b1; vif.lsu_wr_addr = a; vif.lsu_wr_lane_en = le;
        vif.lsu_wr_data = d; vif.lsu_wr_last = l;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic ud, input logic m);
        vif.issue_vld = 1'b1; vif.issue_rs1_addr = rs1; vif.issue_rs1_used = u1;
        vif.issue_rd_addr = rd; vif.issue_rd_used = ud; vif.issue_masked = m;
    endtask

    initial begin
        rst_n = 1'b1;
        vif.issue_vld = 1'b0; vif.issue_rs1_addr = '0; vif.issue_rs2_addr = '0;
        vif.issue_rd_addr = '0; vif.issue_rs1_used = 1'b0; vif.issue_rs2_used = 1'b0;
        vif.issue_rd_used = 1'b0; vif.issue_masked = 1'b0;
        vif.exu_wr_vld = 1'b0; vif.exu_wr_addr = '0; vif.exu_wr_lane_en = '0;
        vif.exu_wr_data = '0; vif.exu_wr_last = 1'b0;
        vif.lsu_wr_vld = 1'b0; vif.lsu_wr_addr = '0; vif.lsu_wr_lane_en = '0;
        vif.lsu_wr_data = '0; vif.lsu_wr_last = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 256'(vif.sb_busy), 256'h0);
        chk("rst_wreq", 256'(vif.vrf_wr_wreq), 256'h0);
        chk("rst_addr", 256'(vif.vrf_wr_addr), 256'h0);
        chk("rst_wdata", vif.vrf_wr_wdata, 256'h0);
        chk("rst_issue_rdy", 256'(vif.issue_rdy), 256'h1);
        chk("rst_exu_rdy", 256'(vif.exu_wr_rdy), 256'h0);
        tick(); tick();
        rst_n = 1'b1;

        // issue rd=v3 sets busy[3]
        issue(5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        #1 chk("issue_v3_rdy", 256'(vif.issue_rdy), 256'h1);
        tick();
        vif.issue_vld = 1'b0;
        #1 chk("busy_v3", 256'(vif.sb_busy), 256'h8);

        // RAW on v3, EXU last beat releases it
        issue(5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        exu_beat(5'd3, 8'hFF, DAT_D1, 1'b1);
        #1 chk("raw_stall", 256'(vif.issue_rdy), 256'h0);
        chk("raw_exu_rdy", 256'(vif.exu_wr_rdy), 256'h1);
        tick();
        vif.exu_wr_vld = 1'b0;
        #1 chk("raw_wreq", 256'(vif.vrf_wr_wreq), 256'hFF);
        chk("raw_addr", 256'(vif.vrf_wr_addr), 256'h3);
        chk("raw_wdata", vif.vrf_wr_wdata, DAT_D1);
        chk("raw_still_stall", 256'(vif.issue_rdy), 256'h0);
        tick();
        chk("raw_clr_busy", 256'(vif.sb_busy), 256'h0);
        chk("raw_wreq_idle", 256'(vif.vrf_wr_wreq), 256'h0);
        chk("raw_addr_hold", 256'(vif.vrf_wr_addr), 256'h3);
        chk("raw_release", 256'(vif.issue_rdy), 256'h1);
        vif.issue_vld = 1'b0;

        // partial lanes on v5; also flips pointer back to EXU
        issue(5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        #1 chk("issue_v5_rdy", 256'(vif.issue_rdy), 256'h1);
        tick();
        vif.issue_vld = 1'b0;
        chk("busy_v5", 256'(vif.sb_busy), 256'h20);
        lsu_beat(5'd5, 8'h0F, DAT_C1, 1'b0);
        #1 chk("pl_lsu_rdy", 256'(vif.lsu_wr_rdy), 256'h1);
        tick();
        lsu_beat(5'd5, 8'h00, DAT_C2, 1'b1);
        exu_beat(5'd6, 8'hFF, DAT_A1, 1'b1);
        #1 chk("pl_wreq_0f", 256'(vif.vrf_wr_wreq), 256'h0F);
        chk("pl_addr", 256'(vif.vrf_wr_addr), 256'h5);
        chk("pl_lock_lsu", 256'(vif.lsu_wr_rdy), 256'h1);
        chk("pl_lock_exu_out", 256'(vif.exu_wr_rdy), 256'h0);
        tick();
        vif.lsu_wr_vld = 1'b0; vif.exu_wr_vld = 1'b0;
        #1 chk("pl_wreq_00", 256'(vif.vrf_wr_wreq), 256'h0);
        chk("pl_wdata_c2", vif.vrf_wr_wdata, DAT_C2);
        chk("pl_busy_held", 256'(vif.sb_busy), 256'h20);
        tick();
        chk("pl_busy_clr", 256'(vif.sb_busy), 256'h0);

        // tie in IDLE with pointer on EXU; EXU burst then LSU without bubble
        exu_beat(5'd7, 8'hFF, DAT_A1, 1'b0);
        lsu_beat(5'd8, 8'hFF, DAT_B1, 1'b1);
        #1 chk("tie_exu_rdy", 256'(vif.exu_wr_rdy), 256'h1);
        chk("tie_lsu_rdy", 256'(vif.lsu_wr_rdy), 256'h0);
        tick();
        exu_beat(5'd7, 8'hFF, DAT_A2, 1'b1);
        #1 chk("burst_exu_rdy", 256'(vif.exu_wr_rdy), 256'h1);
        chk("burst_lsu_rdy", 256'(vif.lsu_wr_rdy), 256'h0);
        chk("burst_wdata_a1", vif.vrf_wr_wdata, DAT_A1);
        tick();
        exu_beat(5'd7, 8'hFF, DAT_A3, 1'b1);
        #1 chk("rr_lsu_rdy", 256'(vif.lsu_wr_rdy), 256'h1);
        chk("rr_exu_rdy", 256'(vif.exu_wr_rdy), 256'h0);
        chk("burst_wdata_a2", vif.vrf_wr_wdata, DAT_A2);
        tick();
        vif.lsu_wr_vld = 1'b0;
        #1 chk("after_lsu_exu_rdy", 256'(vif.exu_wr_rdy), 256'h1);
        chk("lsu_addr", 256'(vif.vrf_wr_addr), 256'h8);
        chk("lsu_wdata_b1", vif.vrf_wr_wdata, DAT_B1);
        chk("lsu_wreq", 256'(vif.vrf_wr_wreq), 256'hFF);
        tick();
        vif.exu_wr_vld = 1'b0;
        chk("exu_wdata_a3", vif.vrf_wr_wdata, DAT_A3);
        chk("nonbusy_write_busy", 256'(vif.sb_busy), 256'h0);

        // mask hazard on v1
        issue(5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        tick();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1 chk("mask_stall", 256'(vif.issue_rdy), 256'h0);
        vif.issue_masked = 1'b0;
        #1 chk("mask_free", 256'(vif.issue_rdy), 256'h1);
        vif.issue_vld = 1'b0;
        chk("busy_v1", 256'(vif.sb_busy), 256'h2);

        // clear v1 and set v9 on the same edge
        exu_beat(5'd1, 8'h03, DAT_E1, 1'b1);
        tick();
        vif.exu_wr_vld = 1'b0;
        issue(5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        #1 chk("sc_issue_rdy", 256'(vif.issue_rdy), 256'h1);
        chk("sc_wreq", 256'(vif.vrf_wr_wreq), 256'h03);
        tick();
        vif.issue_vld = 1'b0;
        chk("sc_busy", 256'(vif.sb_busy), 256'h200);

        // reset inside an LSU burst
        lsu_beat(5'd10, 8'hFF, DAT_F1, 1'b0);
        tick();
        chk("lock_lsu_wreq", 256'(vif.vrf_wr_wreq), 256'hFF);
        exu_beat(5'd11, 8'hFF, DAT_A1, 1'b1);
        #1 chk("lock_lsu_exu_blocked", 256'(vif.exu_wr_rdy), 256'h0);
        rst_n = 1'b0;
        #1 chk("mid_rst_wreq", 256'(vif.vrf_wr_wreq), 256'h0);
        chk("mid_rst_busy", 256'(vif.sb_busy), 256'h0);
        chk("mid_rst_addr", 256'(vif.vrf_wr_addr), 256'h0);
        chk("mid_rst_exu_rdy", 256'(vif.exu_wr_rdy), 256'h1);
        chk("mid_rst_lsu_rdy", 256'(vif.lsu_wr_rdy), 256'h0);
        tick();
        rst_n = 1'b1;
        #1 chk("post_rst_exu_rdy", 256'(vif.exu_wr_rdy), 256'h1);
        chk("post_rst_lsu_rdy", 256'(vif.lsu_wr_rdy), 256'h0);
        tick();
        vif.exu_wr_vld = 1'b0; vif.lsu_wr_vld = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
